// File: rtl/voice_alloc_pkg.sv
// Shared constants for the voice allocator: voice count, note width, age
// width and the bit layout of the flattened per-voice note bus.
package voice_alloc_pkg;

    localparam int OSC_VOICES        = 4;
    localparam int MIDI_PAYLOAD_BITS = 8;
    localparam int VOICE_AGE_W       = 4;

    // Voice v occupies bits [v*width +: width] of the flattened note bus.
    function automatic int note_lsb(input int voice, input int width);
        return voice * width;
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest matching voice (hit), lowest inactive
// voice (free) and the oldest active voice (greatest age, ties to lowest index).
module voice_select
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = OSC_VOICES,
    parameter int AGE_W  = VOICE_AGE_W,
    parameter int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic [VOICES-1:0]            active_i,
    input  logic [VOICES-1:0][AGE_W-1:0] age_i,
    input  logic [VOICES-1:0]            match_i,
    output logic [IDX_W-1:0]             hit_idx_o,
    output logic                         hit_vld_o,
    output logic [IDX_W-1:0]             free_idx_o,
    output logic                         free_vld_o,
    output logic [IDX_W-1:0]             oldest_idx_o
);

    logic [AGE_W-1:0] best_age;
    logic             seen;

    // Priority scans from voice 0 upward; strict '>' keeps ties on the lowest index.
    always_comb begin
        hit_idx_o    = '0;
        hit_vld_o    = 1'b0;
        free_idx_o   = '0;
        free_vld_o   = 1'b0;
        oldest_idx_o = '0;
        best_age     = '0;
        seen         = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (match_i[v] && !hit_vld_o) begin
                hit_vld_o = 1'b1;
                hit_idx_o = IDX_W'(v);
            end
            if (!active_i[v] && !free_vld_o) begin
                free_vld_o = 1'b1;
                free_idx_o = IDX_W'(v);
            end
            if (active_i[v] && (!seen || age_i[v] > best_age)) begin
                seen         = 1'b1;
                best_age     = age_i[v];
                oldest_idx_o = IDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator. Holds per-voice note/active/age registers and
// applies note-off then note-on in one read-modify-write per cycle.
// Optional macro VOICE_ALLOC_STEAL_EN: when defined, a note-on with all voices
// busy steals the oldest voice; otherwise such a note-on is dropped.
//
// Handshake: noteOnStrb_i / noteOffStrb_i are one-cycle valid pulses with an
// implied ready that is always high; note_i is qualified by either strobe, and
// one on/off pair is accepted every cycle with no backpressure.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int VOICES = OSC_VOICES,
    parameter int NOTE_W = MIDI_PAYLOAD_BITS,
    parameter int AGE_W  = VOICE_AGE_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NOTE_W-1:0]            note_i,
    input  logic                         noteOnStrb_i,
    input  logic                         noteOffStrb_i,
    output logic [VOICES*NOTE_W-1:0]     voiceNote_o,
    output logic [VOICES-1:0]            voiceActive_o,
    output logic [VOICES-1:0]            voiceTrig_o,
    output logic [$clog2(VOICES+1)-1:0]  activeCount_o
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int CNT_W = $clog2(VOICES+1);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    logic [VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [VOICES-1:0][AGE_W-1:0]  age_q, age_d;
    logic [VOICES-1:0]             active_q, active_d;
    logic [VOICES-1:0]             trig_q, trig_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [VOICES-1:0] off_hit, active_off, on_match;
    logic [IDX_W-1:0]  hit_idx, free_idx, oldest_idx, tgt;
    logic              hit_vld, free_vld, do_on, load;

    // Note-off first: drop matching voices, then look for note-on hits among the survivors.
    always_comb begin
        off_hit  = '0;
        on_match = '0;
        for (int v = 0; v < VOICES; v++) begin
            off_hit[v] = noteOffStrb_i && active_q[v] && (note_q[v] == note_i);
        end
        active_off = active_q & ~off_hit;
        for (int v = 0; v < VOICES; v++) begin
            on_match[v] = active_off[v] && (note_q[v] == note_i);
        end
    end

    voice_select #(
        .VOICES (VOICES),
        .AGE_W  (AGE_W),
        .IDX_W  (IDX_W)
    ) u_select (
        .active_i     (active_off),
        .age_i        (age_q),
        .match_i      (on_match),
        .hit_idx_o    (hit_idx),
        .hit_vld_o    (hit_vld),
        .free_idx_o   (free_idx),
        .free_vld_o   (free_vld),
        .oldest_idx_o (oldest_idx)
    );

    // Note-on target choice (hit, free, steal) and the resulting next state.
    always_comb begin
        note_d   = note_q;
        age_d    = age_q;
        active_d = active_off;
        trig_d   = '0;
        do_on    = 1'b0;
        load     = 1'b0;
        tgt      = hit_idx;
        if (noteOnStrb_i) begin
            if (hit_vld) begin
                do_on = 1'b1;
            end else if (free_vld) begin
                do_on = 1'b1;
                load  = 1'b1;
                tgt   = free_idx;
            end else if (STEAL_EN) begin
                do_on = 1'b1;
                load  = 1'b1;
                tgt   = oldest_idx;
            end
        end
        if (do_on) begin
            for (int v = 0; v < VOICES; v++) begin
                if (active_off[v] && (IDX_W'(v) != tgt) && (age_q[v] != AGE_MAX)) begin
                    age_d[v] = age_q[v] + AGE_W'(1);
                end
            end
            age_d[tgt]    = '0;
            active_d[tgt] = 1'b1;
            trig_d[tgt]   = 1'b1;
            if (load) begin
                note_d[tgt] = note_i;
            end
        end
        count_d = '0;
        for (int v = 0; v < VOICES; v++) begin
            count_d = count_d + CNT_W'(active_d[v]);
        end
    end

    // State and output registers; reset wins over any strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            note_q   <= '0;
            age_q    <= '0;
            active_q <= '0;
            trig_q   <= '0;
            count_q  <= '0;
        end else begin
            note_q   <= note_d;
            age_q    <= age_d;
            active_q <= active_d;
            trig_q   <= trig_d;
            count_q  <= count_d;
        end
    end

    for (genvar gv = 0; gv < VOICES; gv++) begin : g_pack
        assign voiceNote_o[note_lsb(gv, NOTE_W) +: NOTE_W] = note_q[gv];
    end

    assign voiceActive_o = active_q;
    assign voiceTrig_o   = trig_q;
    assign activeCount_o = count_q;

endmodule
